// File: rtl/aes_bist_ctrl_if.sv
// Control/status bundle between the AES BIST sequencer, the system/debug
// controller, the TPG/MISR pair and the datapath bist_mode mux.
interface aes_bist_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] golden_sig;
  logic [WIDTH-1:0] misr_sig;
  logic             misr_rst;
  logic             misr_en;
  logic             tpg_rst;
  logic             tpg_en;
  logic             bist_mode;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] phase_cnt;

  // Environment side: controller requests plus signature sources.
  modport master (
    output start, abort, golden_sig, misr_sig,
    input  misr_rst, misr_en, tpg_rst, tpg_en, bist_mode,
    input  busy, done, pass, fail, phase_cnt
  );

  // Sequencer side.
  modport slave (
    input  start, abort, golden_sig, misr_sig,
    output misr_rst, misr_en, tpg_rst, tpg_en, bist_mode,
    output busy, done, pass, fail, phase_cnt
  );
endinterface

// File: rtl/aes_bist_ctrl.sv
// BIST sequencer for the 8-bit AES datapath: INIT, WARMUP, RUN, FLUSH and
// COMPARE phases, then a one-cycle DONE pulse with a sticky pass/fail result.
module aes_bist_ctrl #(
  parameter int WIDTH         = 8,
  parameter int NUM_PATTERNS  = 256,
  parameter int WARMUP_CYCLES = 17,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic           clk,
  input  logic           rst,
  aes_bist_ctrl_if.slave bus
);

  localparam int MAX_LEN_WS = (WARMUP_CYCLES > SETTLE_CYCLES) ? WARMUP_CYCLES : SETTLE_CYCLES;
  localparam int MAX_LEN    = (NUM_PATTERNS > MAX_LEN_WS) ? NUM_PATTERNS : MAX_LEN_WS;

  generate
    if (NUM_PATTERNS < 1) begin : g_bad_num_patterns
      $error("aes_bist_ctrl: NUM_PATTERNS must be at least 1");
    end
    if ((MAX_LEN >> CNT_W) != 0) begin : g_bad_cnt_w
      $error("aes_bist_ctrl: CNT_W too narrow for the longest phase");
    end
    if (WARMUP_CYCLES < 0 || SETTLE_CYCLES < 0) begin : g_bad_len
      $error("aes_bist_ctrl: phase lengths must not be negative");
    end
  endgenerate

  // Terminal counts; a zero-length phase is never entered, so its value is unused.
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_CYCLES > 0 ? WARMUP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WARMUP,
    S_RUN,
    S_FLUSH,
    S_COMPARE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic misr_rst;
    logic misr_en;
    logic tpg_rst;
    logic tpg_en;
    logic bist_mode;
    logic busy;
    logic done;
    logic pass;
    logic fail;
  } outs_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  outs_t            outs_q, outs_d;
  logic [WIDTH-1:0] misr_s, golden_s;
  logic             match;
  logic             aborting;
  logic             accepting;

  assign misr_s   = bus.misr_sig;
  assign golden_s = bus.golden_sig;
  assign match    = (misr_s == golden_s);

  // abort is honoured only while a test is actually in flight.
  assign aborting  = bus.abort && (state != S_IDLE) && (state != S_DONE);
  assign accepting = (state == S_IDLE) && bus.start && !bus.abort;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (accepting) state_d = S_INIT;
      S_INIT:    state_d = (WARMUP_CYCLES > 0) ? S_WARMUP : S_RUN;
      S_WARMUP:  if (cnt == WARM_LAST) state_d = S_RUN;
      S_RUN:     if (cnt == RUN_LAST) state_d = (SETTLE_CYCLES > 0) ? S_FLUSH : S_COMPARE;
      S_FLUSH:   if (cnt == FLUSH_LAST) state_d = S_COMPARE;
      S_COMPARE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (aborting) state_d = S_IDLE;
  end

  // Counter restarts at 0 on entry to a counted phase and reads 0 elsewhere.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state) &&
        (state_d == S_WARMUP || state_d == S_RUN || state_d == S_FLUSH)) begin
      cnt_d = cnt + CNT_ONE;
    end
  end

  // Moore outputs decoded from the next state so they register alongside it.
  always_comb begin
    outs_d      = '0;
    outs_d.pass = outs_q.pass;
    outs_d.fail = outs_q.fail;
    case (state_d)
      S_INIT: begin
        outs_d.misr_rst  = 1'b1;
        outs_d.tpg_rst   = 1'b1;
        outs_d.bist_mode = 1'b1;
        outs_d.busy      = 1'b1;
      end
      S_WARMUP, S_RUN: begin
        outs_d.tpg_en    = 1'b1;
        outs_d.misr_en   = 1'b1;
        outs_d.bist_mode = 1'b1;
        outs_d.busy      = 1'b1;
      end
      S_FLUSH: begin
        outs_d.misr_en   = 1'b1;
        outs_d.bist_mode = 1'b1;
        outs_d.busy      = 1'b1;
      end
      S_COMPARE: begin
        outs_d.bist_mode = 1'b1;
        outs_d.busy      = 1'b1;
      end
      S_DONE:  outs_d.done = 1'b1;
      default: ;
    endcase

    if (accepting || aborting) begin
      outs_d.pass = 1'b0;
      outs_d.fail = 1'b0;
    end else if (state == S_COMPARE) begin
      outs_d.pass = match;
      outs_d.fail = !match;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-high, matching the rest of this
    // clock domain; it is sampled only on the rising edge.
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      outs_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      outs_q <= outs_d;
    end
  end

  assign bus.misr_rst  = outs_q.misr_rst;
  assign bus.misr_en   = outs_q.misr_en;
  assign bus.tpg_rst   = outs_q.tpg_rst;
  assign bus.tpg_en    = outs_q.tpg_en;
  assign bus.bist_mode = outs_q.bist_mode;
  assign bus.busy      = outs_q.busy;
  assign bus.done      = outs_q.done;
  assign bus.pass      = outs_q.pass;
  assign bus.fail      = outs_q.fail;
  assign bus.phase_cnt = cnt;

endmodule

// File: doc/aes_bist_ctrl.md
Name: aes_bist_ctrl

Overview:
- BIST sequencer for the 8-bit AES datapath.
- On request it does the following, in order:
  - resets the test-pattern generator (TPG) and the signature MISR;
  - runs a warm-up interval, then a fixed number of pattern cycles;
  - flushes the datapath pipeline;
  - compares the final MISR signature against a golden value.
- Sits between the system/debug controller (start/abort/status) and the TPG, MISR and datapath bist_mode mux.

Parameters:
- WIDTH, 8, signature width; matches the MISR.
- NUM_PATTERNS, 256, number of RUN cycles. Must be ≥1; elaboration error otherwise.
- WARMUP_CYCLES, 17, cycles with TPG and MISR enabled before RUN. 0 skips WARMUP.
- SETTLE_CYCLES, 2, datapath latency flushed after the last pattern. TPG is stopped, MISR keeps capturing. 0 skips FLUSH.
- CNT_W, 16, phase counter width. Must hold max(NUM_PATTERNS, WARMUP_CYCLES, SETTLE_CYCLES).

Ports:
- clk          in   1      clock
- rst          in   1      synchronous, active-high reset
- start        in   1      level; sampled only in IDLE
- abort        in   1      level; terminates an in-progress test
- golden_sig   in   WIDTH  expected signature; sampled in COMPARE
- misr_sig     in   WIDTH  current MISR signature
- misr_rst     out  1      MISR synchronous reset
- misr_en      out  1      MISR capture enable
- tpg_rst      out  1      TPG reseed
- tpg_en       out  1      TPG advance enable
- bist_mode    out  1      datapath input mux selects TPG
- busy         out  1      test in progress
- done         out  1      one-cycle completion pulse
- pass         out  1      sticky result: signature matched
- fail         out  1      sticky result: signature mismatched
- phase_cnt    out  CNT_W  current phase counter (debug)

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, phase_cnt=0.
  - All outputs 0: misr_rst, misr_en, tpg_rst, tpg_en, bist_mode, busy, done, pass, fail.
  - rst mid-test aborts immediately, with no done pulse.
- All outputs are registered (Moore), decoded from next state.
- States and transitions:
  - IDLE: start=1 & abort=0 → INIT. Also clears pass/fail at the same edge.
  - INIT (1 cycle): misr_rst=1, tpg_rst=1, bist_mode=1, busy=1.
    - → WARMUP if WARMUP_CYCLES>0, else → RUN.
  - WARMUP (WARMUP_CYCLES cycles): tpg_en=1, misr_en=1, bist_mode=1, busy=1.
  - RUN (NUM_PATTERNS cycles): same outputs as WARMUP.
    - → FLUSH if SETTLE_CYCLES>0, else → COMPARE.
  - FLUSH (SETTLE_CYCLES cycles): tpg_en=0, misr_en=1, bist_mode=1, busy=1.
  - COMPARE (1 cycle): all enables 0, bist_mode=1, busy=1.
    - Register match = (misr_sig == golden_sig).
  - DONE (1 cycle): done=1, busy=0, bist_mode=0.
    - pass=match, fail=!match; both held until the next accepted start or rst.
    - → IDLE unconditionally.
- Phase counter:
  - Loads 0 on entry to each counted state.
  - Increments each cycle in that state.
  - Exits when phase_cnt == LEN-1.
  - Never wraps within a phase.
  - phase_cnt=0 outside counted states.
- Total misr_en-high cycles = WARMUP_CYCLES + NUM_PATTERNS + SETTLE_CYCLES.
- Total tpg_en-high cycles = WARMUP_CYCLES + NUM_PATTERNS.
- abort=1 in any state except IDLE/DONE:
  - next state IDLE; all enables drop the next cycle;
  - pass=fail=0, no done pulse.
- abort in DONE is ignored; the result stands.
- Simultaneous start & abort in IDLE: abort wins, stay IDLE.
- start while busy: ignored. Start held high through DONE re-triggers from IDLE on the following edge, which is legal.
- golden_sig and misr_sig are sampled only in COMPARE; changes elsewhere have no effect.

Test Plan:
Bench parameters: WARMUP_CYCLES=2, NUM_PATTERNS=4, SETTLE_CYCLES=1. Start is sampled at edge 0; cycles below are numbered from that edge.
1. Nominal pass, golden_sig=misr_sig=8'h5A:
   - INIT cycle 1, with misr_rst and tpg_rst high.
   - misr_en high cycles 2–8 (7 cycles); tpg_en high cycles 2–7 (6 cycles).
   - busy high cycles 1–9.
   - done pulse cycle 10, with pass=1, fail=0 from cycle 10 onward.
2. Mismatch, misr_sig=8'h5A, golden_sig=8'h5B:
   - Identical timing to scenario 1.
   - Cycle 10: done=1, pass=0, fail=1; held after start deasserted.
3. Abort asserted in cycle 5 (RUN):
   - Cycle 6: state IDLE, misr_en=tpg_en=busy=0.
   - done never pulses; pass=fail=0.
4. Re-run after fail:
   - New start clears fail at INIT entry.
   - Matching signature yields pass=1 at the new done.
5. Zero-length phases (rebuild with WARMUP_CYCLES=0, SETTLE_CYCLES=0):
   - RUN cycles 2–5, COMPARE cycle 6, done cycle 7.
   - misr_en and tpg_en each high exactly 4 cycles.
6. Corner cases:
   - start & abort together in IDLE: no transition.
   - rst asserted in WARMUP: all outputs 0 next cycle.
   - start pulsed while busy: no effect on timing.
